// File: rtl/hard_mem_arb_pkg.sv
// Shared constants and types for the arbitrated 1RW memory front end.
// The response struct is sized for the default width and the maximum number of requesters, which is four.
package hard_mem_arb_pkg;

  localparam int hmem_width_gp   = 64;
  localparam int hmem_els_gp     = 512;
  localparam int hmem_max_req_gp = 4;

  typedef logic [$clog2(hmem_max_req_gp)-1:0] req_idx_t;

  typedef struct packed {
    req_idx_t                 owner;
    logic [hmem_width_gp-1:0] data;
  } resp_s;

endpackage

// File: rtl/hard_mem_arb_rr.sv
// Round-robin picker: the first eligible requester after last_i, wrapping, wins.
module hard_mem_arb_rr
  import hard_mem_arb_pkg::*;
#(
  parameter int num_req_p = 2
) (
  input  logic [num_req_p-1:0] elig_i,
  input  req_idx_t             last_i,
  output logic [num_req_p-1:0] grant_o,
  output req_idx_t             idx_o
);

  logic w_found;

  // Visit the candidates in priority order; the index is compared rather than used to select bits.
  always_comb begin
    grant_o = '0;
    idx_o   = last_i;
    w_found = 1'b0;
    for (int off = 1; off <= num_req_p; off++) begin
      for (int k = 0; k < num_req_p; k++) begin
        if (!w_found && elig_i[k] && (k == (int'(last_i) + off) % num_req_p)) begin
          w_found    = 1'b1;
          grant_o[k] = 1'b1;
          idx_o      = req_idx_t'(k);
        end
      end
    end
  end

endmodule

// File: rtl/hard_mem_1rw_d512_w64_arb.sv
// Arbitrates several requesters onto one 1RW synchronous-read memory.
// Only one read is outstanding at a time, and its response waits until the requester consumes it.
module hard_mem_1rw_d512_w64_arb
  import hard_mem_arb_pkg::*;
#(
  parameter  int width_p       = hmem_width_gp,
  parameter  int els_p         = hmem_els_gp,
  parameter  int num_req_p     = 2,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p-1:0]             v_i,
  input  logic [num_req_p-1:0]             w_i,
  input  logic [num_req_p*addr_width_lp-1:0] addr_i,
  input  logic [num_req_p*width_p-1:0]     data_i,
  output logic [num_req_p-1:0]             yumi_o,
  output logic [num_req_p-1:0]             v_o,
  output logic [width_p-1:0]               data_o,
  input  logic [num_req_p-1:0]             yumi_i,
  output logic                             mem_v_o,
  output logic                             mem_w_o,
  output logic [addr_width_lp-1:0]         mem_addr_o,
  output logic [width_p-1:0]               mem_data_o,
  input  logic [width_p-1:0]               mem_data_i
);

  logic                 r_inflight;
  req_idx_t             r_rd_owner;
  req_idx_t             r_last;
  logic                 r_resp_v;
  resp_s                r_resp;

  logic [num_req_p-1:0] w_elig;
  logic [num_req_p-1:0] w_grant;
  logic [num_req_p-1:0] w_owner_hot;
  req_idx_t             w_idx;
  logic                 w_resp_pop;
  logic                 w_read_ok;
  logic                 w_acc_read;

  // Consumption only counts on the owner's bit, so a stray yumi_i is ignored.
  assign w_resp_pop = |(v_o & yumi_i);
  assign w_read_ok  = ~r_inflight & (~r_resp_v | w_resp_pop);

  generate
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
      assign w_owner_hot[gi] = (r_resp.owner == req_idx_t'(gi));
      assign v_o[gi]         = r_resp_v & w_owner_hot[gi];
      assign w_elig[gi]      = v_i[gi] & (w_i[gi] | w_read_ok);
    end
  endgenerate

  hard_mem_arb_rr #(.num_req_p(num_req_p)) u_rr (
    .elig_i  (w_elig),
    .last_i  (r_last),
    .grant_o (w_grant),
    .idx_o   (w_idx)
  );

  assign yumi_o     = w_grant & ~{num_req_p{reset_i}};
  assign mem_v_o    = (|w_grant) & ~reset_i;
  assign w_acc_read = |(w_grant & ~w_i);
  assign data_o     = r_resp.data;

  always_comb begin
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (w_grant[k]) begin
        mem_w_o    = w_i[k];
        mem_addr_o = addr_i[k*addr_width_lp +: addr_width_lp];
        mem_data_o = data_i[k*width_p +: width_p];
      end
    end
  end

  // mem_data_i is captured at the end of the in-flight cycle, before any write issued in that cycle has landed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_inflight <= 1'b0;
      r_rd_owner <= '0;
      r_last     <= req_idx_t'(num_req_p - 1);
      r_resp_v   <= 1'b0;
      r_resp     <= '0;
    end else begin
      if (|w_grant) r_last <= w_idx;
      r_inflight <= w_acc_read;
      if (w_acc_read) r_rd_owner <= w_idx;
      if (r_inflight) begin
        r_resp_v     <= 1'b1;
        r_resp.owner <= r_rd_owner;
        r_resp.data  <= mem_data_i;
      end else if (w_resp_pop) begin
        r_resp_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hard_mem_1rw_d512_w64_arb.sv
// Directed scenarios plus a random mix for the arbitrated 1RW memory.
// A monitor scores every accept and response against a reference memory.
module tb_hard_mem_1rw_d512_w64_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  v_in, w_in, yumi_in;
  logic [8:0]  a0, a1;
  logic [63:0] d0, d1;
  logic [1:0]  yumi_o, v_o;
  logic [63:0] data_o;
  logic        mem_v_o, mem_w_o;
  logic [8:0]  mem_addr_o;
  logic [63:0] mem_data_o, mem_data_i;

  logic [63:0] mem [512];
  logic [63:0] model [512];
  logic [8:0]  r_raddr;

  typedef struct packed {
    logic [1:0]  owner;
    logic [63:0] data;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int mon_g;
  exp_t mon_e;

  always #5 clk = ~clk;

  hard_mem_1rw_d512_w64_arb dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .v_i        (v_in),
    .w_i        (w_in),
    .addr_i     ({a1, a0}),
    .data_i     ({d1, d0}),
    .yumi_o     (yumi_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_in),
    .mem_v_o    (mem_v_o),
    .mem_w_o    (mem_w_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i)
  );

  // 1RW synchronous-read memory with a read-address register; not touched by reset.
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) mem[mem_addr_o] <= mem_data_o;
      else         r_raddr <= mem_addr_o;
    end
  end
  assign mem_data_i = mem[r_raddr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [8:0] x0,
                       input logic [8:0] x1, input logic [63:0] y0, input logic [63:0] y1,
                       input logic [1:0] yi);
    v_in = v; w_in = w; a0 = x0; a1 = x1; d0 = y0; d1 = y1; yumi_in = yi;
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepts update the model or enqueue the expected read result; consumed responses dequeue.
  always @(negedge clk) begin
    if (!rst) begin
      if (yumi_o != 2'b00) begin
        mon_g = yumi_o[1] ? 1 : 0;
        check("yumi_onehot", 64'(yumi_o == 2'b01 || yumi_o == 2'b10), 64'd1);
        check("mem_v", 64'(mem_v_o), 64'd1);
        check("mem_w", 64'(mem_w_o), 64'(w_in[mon_g]));
        check("mem_addr", 64'(mem_addr_o), 64'(mon_g == 1 ? a1 : a0));
        if (w_in[mon_g]) begin
          check("mem_data", mem_data_o, mon_g == 1 ? d1 : d0);
          model[mon_g == 1 ? a1 : a0] = mon_g == 1 ? d1 : d0;
          $display("t=%0t accept write req%0d addr=%0d", $time, mon_g, mon_g == 1 ? a1 : a0);
        end else begin
          mon_e.owner = 2'(mon_g);
          mon_e.data  = model[mon_g == 1 ? a1 : a0];
          q.push_back(mon_e);
          $display("t=%0t accept read req%0d addr=%0d", $time, mon_g, mon_g == 1 ? a1 : a0);
        end
      end else begin
        check("mem_idle", 64'(mem_v_o), 64'd0);
      end
      if (v_o != 2'b00) begin
        if (q.size() == 0) begin
          check("resp_spurious", 64'(v_o), 64'd0);
        end else begin
          mon_e = q[0];
          check("resp_owner", 64'(v_o), 64'(mon_e.owner == 2'd0 ? 2'b01 : 2'b10));
          if ((v_o & yumi_in) != 2'b00) begin
            check("resp_data", data_o, mon_e.data);
            $display("t=%0t response req%0d data=%h", $time, mon_e.owner, data_o);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]   = 64'd0;
      model[i] = 64'd0;
    end
    r_raddr = 9'd0;

    // Reset: outputs quiet even with requests pending
    drive(2'b11, 2'b11, 9'd1, 9'd2, 64'h11, 64'h22, 2'b11);
    @(negedge clk);
    check("rst_yumi", 64'(yumi_o), 64'd0);
    check("rst_vo", 64'(v_o), 64'd0);
    check("rst_memv", 64'(mem_v_o), 64'd0);
    check("rst_data", data_o, 64'd0);
    to_drive();
    rst = 1'b0;

    // Read latency
    drive(2'b01, 2'b01, 9'd5, 9'd0, 64'hA5A5, 64'd0, 2'b00);
    @(negedge clk); check("lat_wr_grant", 64'(yumi_o), 64'h1); to_drive();
    drive(2'b10, 2'b00, 9'd0, 9'd5, 64'd0, 64'd0, 2'b00);
    @(negedge clk); check("lat_rd_grant", 64'(yumi_o), 64'h2); to_drive();
    drive(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, 2'b00);
    @(negedge clk); check("lat_n1_vo", 64'(v_o), 64'h0); to_drive();
    drive(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, 2'b10);
    @(negedge clk); check("lat_n2_vo", 64'(v_o), 64'h2); check("lat_n2_data", data_o, 64'hA5A5); to_drive();
    drive(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, 2'b00);
    @(negedge clk); check("lat_popped", 64'(v_o), 64'h0); to_drive();

    // Fairness directly after reset
    rst = 1'b1;
    @(negedge clk); to_drive();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 2'b11, 9'd20, 9'd21, 64'(100 + i), 64'(200 + i), 2'b00);
      @(negedge clk); check("fair", 64'(yumi_o), (i % 2 == 0) ? 64'h1 : 64'h2); to_drive();
    end

    // Backpressure: held response blocks other reads; illegal yumi_i ignored
    drive(2'b01, 2'b01, 9'd7, 9'd0, 64'h77, 64'd0, 2'b00);
    @(negedge clk); check("bp_wr_grant", 64'(yumi_o), 64'h1); to_drive();
    drive(2'b01, 2'b00, 9'd7, 9'd0, 64'd0, 64'd0, 2'b00);
    @(negedge clk); check("bp_rd_grant", 64'(yumi_o), 64'h1); to_drive();
    drive(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, 2'b00);
    to_drive();
    for (int k = 0; k < 5; k++) begin
      drive(2'b10, 2'b00, 9'd0, 9'd3, 64'd0, 64'd0, (k == 2) ? 2'b10 : 2'b00);
      @(negedge clk);
      check("bp_hold_yumi", 64'(yumi_o), 64'h0);
      check("bp_hold_vo", 64'(v_o), 64'h1);
      check("bp_hold_data", data_o, 64'h77);
      to_drive();
    end
    drive(2'b10, 2'b00, 9'd0, 9'd3, 64'd0, 64'd0, 2'b01);
    @(negedge clk); check("bp_release_grant", 64'(yumi_o), 64'h2); to_drive();
    drive(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, 2'b00);
    @(negedge clk); check("bp_gap_vo", 64'(v_o), 64'h0); to_drive();
    drive(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, 2'b10);
    @(negedge clk); check("bp_req1_vo", 64'(v_o), 64'h2); to_drive();

    // Write-after-read hazard on the same address
    drive(2'b01, 2'b01, 9'd9, 9'd0, 64'h1, 64'd0, 2'b00);
    @(negedge clk); check("hz_init_wr", 64'(yumi_o), 64'h1); to_drive();
    drive(2'b10, 2'b00, 9'd0, 9'd9, 64'd0, 64'd0, 2'b00);
    @(negedge clk); check("hz_rd_grant", 64'(yumi_o), 64'h2); to_drive();
    drive(2'b01, 2'b01, 9'd9, 9'd0, 64'h2, 64'd0, 2'b00);
    @(negedge clk); check("hz_wr_n1", 64'(yumi_o), 64'h1); to_drive();
    drive(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, 2'b10);
    @(negedge clk); check("hz_old_data", data_o, 64'h1); to_drive();
    drive(2'b10, 2'b00, 9'd0, 9'd9, 64'd0, 64'd0, 2'b00);
    @(negedge clk); check("hz_rd2_grant", 64'(yumi_o), 64'h2); to_drive();
    drive(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, 2'b00);
    to_drive();
    drive(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, 2'b10);
    @(negedge clk); check("hz_new_data", data_o, 64'h2); to_drive();

    // Reset in the in-flight cycle of a read
    drive(2'b10, 2'b00, 9'd0, 9'd5, 64'd0, 64'd0, 2'b00);
    @(negedge clk); check("rm_rd_grant", 64'(yumi_o), 64'h2); to_drive();
    drive(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, 2'b00);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rm_vo", 64'(v_o), 64'h0);
    check("rm_memv", 64'(mem_v_o), 64'h0);
    q.delete();
    to_drive();
    to_drive();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("rm_after_vo", 64'(v_o), 64'h0); to_drive();
    end
    drive(2'b11, 2'b11, 9'd30, 9'd31, 64'h30, 64'h31, 2'b00);
    @(negedge clk); check("rm_first_grant", 64'(yumi_o), 64'h1); to_drive();

    // Random mix
    for (int i = 0; i < 10000; i++) begin
      drive(2'($urandom), 2'($urandom), 9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)),
            {$urandom, $urandom}, {$urandom, $urandom}, v_o & 2'($urandom));
      to_drive();
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      drive(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, v_o);
      to_drive();
    end
    @(negedge clk);
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
